// File: rtl/local_pht_pkg.sv
// Shared types for the local pattern history table: counter encoding, FSM states
// and the 2-bit saturating counter update.
package local_pht_pkg;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} pht_ctr_t;

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} pht_state_t;

  localparam pht_ctr_t PHT_CTR_INIT = WNT;

  function automatic pht_ctr_t sat_update(input pht_ctr_t ctr, input logic taken);
    case (ctr)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      ST:      return taken ? ST  : WT;
      default: return ctr;
    endcase
  endfunction

endpackage

// File: rtl/local_pht_ram.sv
// Counter storage: one async read port, one sync write port, no reset.
// Contents are initialised by the local_pht init FSM, never here.
module pht_counter_ram
  import local_pht_pkg::*;
#(
  parameter int idx_width = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [idx_width-1:0] waddr,
  input  pht_ctr_t             wdata,
  input  logic [idx_width-1:0] raddr,
  output pht_ctr_t             rdata
);

  pht_ctr_t mem [2**idx_width];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/local_pht.sv
// Local pattern history table: PC+history indexed 2-bit counters with a
// registered lookup and single-cycle training. Optional macro LOCAL_PHT_XOR_HASH_EN
// folds PC bits into the history part of the index.
//
// state   | meaning
// S_INIT  | writing WNT to every entry, one per cycle; lookups/updates dropped
// S_READY | table live: one lookup and one update accepted per cycle
module local_pht
  import local_pht_pkg::*;
#(
  parameter int hist_width = 6,
  parameter int s_index    = 3,
  parameter int idx_width  = s_index + hist_width
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  input  logic [hist_width-1:0] lookup_history,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [1:0]            pred_ctr,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic [hist_width-1:0] update_history,
  input  logic                  update_taken
);

  localparam int depth = 2**idx_width;
  typedef logic [idx_width-1:0] idx_t;

  function automatic idx_t pht_index(input logic [31:0] pc, input logic [hist_width-1:0] hist);
`ifdef LOCAL_PHT_XOR_HASH_EN
    return {pc[s_index+1:2], hist ^ pc[hist_width+s_index+1:s_index+2]};
`else
    return {pc[s_index+1:2], hist};
`endif
  endfunction

  pht_state_t state, state_nx;
  idx_t       init_ptr;
  idx_t       lkp_idx, upd_idx;
  pht_ctr_t   lkp_rdata, upd_rdata, lkp_ctr;
  logic       we;
  idx_t       waddr;
  pht_ctr_t   wdata;
  logic       lkp_accept;
  logic       unused_pc;

  assign unused_pc = ^{lookup_pc, update_pc};

  assign lkp_idx = pht_index(lookup_pc, lookup_history);
  assign upd_idx = pht_index(update_pc, update_history);

  always_comb begin
    state_nx = state;
    if (state == S_INIT && init_ptr == idx_t'(depth - 1)) state_nx = S_READY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == S_READY);
      if (state == S_INIT) init_ptr <= init_ptr + idx_t'(1);
    end
  end

  // Write port is shared between init sweep and training.
  always_comb begin
    we    = 1'b0;
    waddr = init_ptr;
    wdata = PHT_CTR_INIT;
    if (!reset) begin
      if (state == S_INIT) begin
        we = 1'b1;
      end else begin
        we    = update_valid;
        waddr = upd_idx;
        wdata = sat_update(upd_rdata, update_taken);
      end
    end
  end

  // Write-first: a same-index update in this cycle is visible to the lookup.
  assign lkp_accept = lookup_valid && (state == S_READY);
  assign lkp_ctr    = (we && state == S_READY && waddr == lkp_idx) ? wdata : lkp_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= 2'b00;
    end else begin
      pred_valid <= lkp_accept;
      if (lkp_accept) begin
        pred_taken <= lkp_ctr[1];
        pred_ctr   <= lkp_ctr;
      end
    end
  end

  // Two identically-written copies give independent read ports for lookup and update.
  pht_counter_ram #(.idx_width(idx_width)) u_ram_lkp (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (lkp_idx),
    .rdata (lkp_rdata)
  );

  pht_counter_ram #(.idx_width(idx_width)) u_ram_upd (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (upd_idx),
    .rdata (upd_rdata)
  );

endmodule

// File: tb/tb_local_pht.sv
// Directed bench for local_pht: init timing, table-driven training vectors,
// bypass, aliasing, reset restart and an index back-door check.
module tb_local_pht;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [5:0]  lookup_history;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_history;
  logic        update_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  local_pht u_dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .lookup_history (lookup_history),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_history (update_history),
    .update_taken   (update_taken)
  );

  typedef struct {
    string       name;
    logic        lv;
    logic [31:0] lpc;
    logic [5:0]  lh;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  uh;
    logic        ut;
    logic        exp_pv;
    logic [1:0]  exp_ctr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic lv, input logic [31:0] lpc,
                              input logic [5:0] lh, input logic uv, input logic [31:0] upc,
                              input logic [5:0] uh, input logic ut, input logic exp_pv,
                              input logic [1:0] exp_ctr);
    vec_t v;
    v.name = name; v.lv = lv; v.lpc = lpc; v.lh = lh; v.uv = uv; v.upc = upc;
    v.uh = uh; v.ut = ut; v.exp_pv = exp_pv; v.exp_ctr = exp_ctr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic lv, input logic [31:0] lpc, input logic [5:0] lh,
                      input logic uv, input logic [31:0] upc, input logic [5:0] uh,
                      input logic ut);
    @(negedge clk);
    lookup_valid = lv; lookup_pc = lpc; lookup_history = lh;
    update_valid = uv; update_pc = upc; update_history = uh; update_taken = ut;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pred(input string name, input logic exp_pv, input logic [1:0] exp_ctr);
    check({name, "_valid"}, pred_valid, exp_pv);
    check({name, "_ctr"}, pred_ctr, exp_ctr);
    check({name, "_taken"}, pred_taken, exp_ctr[1]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge just after reset release; lookups stay requested throughout
  // and an update to entry X is issued on init cycle 50.
  task automatic run_init(input int stop_at, output int cycles);
    cycles = 0;
    lookup_valid = 1'b1; lookup_pc = 32'h0; lookup_history = 6'h11;
    update_pc = 32'h0; update_history = 6'h11; update_taken = 1'b1;
    while (!ready && cycles < stop_at) begin
      update_valid = (cycles == 49);
      @(posedge clk);
      #1;
      cycles++;
      check("init_pred_valid", pred_valid, 1'b0);
      @(negedge clk);
    end
    update_valid = 1'b0;
    lookup_valid = 1'b0;
  endtask

  localparam logic [31:0] PA = 32'h10, PB = 32'h14, PD = 32'h18, PX = 32'h0;
  localparam logic [5:0]  HA = 6'h2A, HC = 6'h05, HD = 6'h00, HX = 6'h11;

  initial begin
    int cyc;
    logic [8:0] bd_idx;
    logic [8:0] e;

    reset = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0; lookup_history = '0;
    update_valid = 1'b0; update_pc = '0; update_history = '0; update_taken = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b0);
    check_pred("rst_pred", 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    run_init(2000, cyc);
    check("init_cycles", cyc, 512);
    check("init_ready", ready, 1'b1);

    step(1'b1, PX, HX, 1'b0, 0, 0, 1'b0);
    check_pred("init_update_dropped", 1'b1, 2'b01);

    for (int i = 0; i < 512; i++) begin
      e = 9'(i);
      step(1'b1, {27'd0, e[8:6], 2'b00}, e[5:0], 1'b0, 0, 0, 1'b0);
      check("sweep_ctr", {23'd0, e, pred_ctr}, {23'd0, e, 2'b01});
    end

    vq.push_back(mk("a_look0",  1, PA, HA, 0, 0,  0,  0, 1, 2'b01));
    vq.push_back(mk("a_t1",     0, 0,  0,  1, PA, HA, 1, 0, 2'b01));
    vq.push_back(mk("a_t2",     0, 0,  0,  1, PA, HA, 1, 0, 2'b01));
    vq.push_back(mk("a_t3",     0, 0,  0,  1, PA, HA, 1, 0, 2'b01));
    vq.push_back(mk("a_sat_st", 1, PA, HA, 0, 0,  0,  0, 1, 2'b11));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk("a_nt",   0, 0,  0,  1, PA, HA, 0, 0, 2'b11));
    vq.push_back(mk("a_sat_snt",1, PA, HA, 0, 0,  0,  0, 1, 2'b00));
    vq.push_back(mk("c_bypass", 1, PA, HC, 1, PA, HC, 1, 1, 2'b10));
    vq.push_back(mk("b_alias",  1, PB, HA, 0, 0,  0,  0, 1, 2'b01));
    vq.push_back(mk("diff_idx", 1, PA, HA, 1, PB, HA, 1, 1, 2'b00));
    vq.push_back(mk("b_trained",1, PB, HA, 0, 0,  0,  0, 1, 2'b10));
    vq.push_back(mk("d_t1",     0, 0,  0,  1, PD, HD, 1, 0, 2'b10));
    vq.push_back(mk("d_t2",     0, 0,  0,  1, PD, HD, 1, 0, 2'b10));
    vq.push_back(mk("d_b2b",    1, PD, HD, 0, 0,  0,  0, 1, 2'b11));
    vq.push_back(mk("d_nt_byp", 1, PD, HD, 1, PD, HD, 0, 1, 2'b10));
    vq.push_back(mk("idle_hold",0, 0,  0,  0, 0,  0,  0, 0, 2'b10));

    foreach (vq[i]) begin
      step(vq[i].lv, vq[i].lpc, vq[i].lh, vq[i].uv, vq[i].upc, vq[i].uh, vq[i].ut);
      check_pred(vq[i].name, vq[i].exp_pv, vq[i].exp_ctr);
    end

`ifdef LOCAL_PHT_XOR_HASH_EN
    bd_idx = 9'h00C;
`else
    bd_idx = 9'h004;
`endif
    step(1'b1, 32'h100, 6'h04, 1'b1, 32'h100, 6'h04, 1'b1);
    check_pred("hash_same_entry", 1'b1, 2'b10);
    check("hash_backdoor", u_dut.u_ram_lkp.mem[bd_idx], 2'b10);

    reset_pulse();
    run_init(100, cyc);
    check("restart_mid_ready", ready, 1'b0);
    reset_pulse();
    run_init(2000, cyc);
    check("restart_cycles", cyc, 512);
    step(1'b1, PX, HX, 1'b0, 0, 0, 1'b0);
    check_pred("restart_x", 1'b1, 2'b01);
    step(1'b1, PA, HA, 1'b0, 0, 0, 1'b0);
    check_pred("restart_a", 1'b1, 2'b01);
    step(1'b1, PB, HA, 1'b1, PB, HA, 1'b1);
    check_pred("restart_b_byp", 1'b1, 2'b10);

    @(negedge clk);
    reset = 1'b1;
    lookup_valid = 1'b1; lookup_pc = PB; lookup_history = HA;
    @(posedge clk);
    #1;
    check("midrun_rst_ready", ready, 1'b0);
    check_pred("midrun_rst", 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    lookup_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
